// File: rtl/adc_readout_pkg.sv
// Shared types for the per-row ADC readout path: pixel word width, pixel word
// type and the serializer state encoding.
package adc_readout_pkg;

    localparam int PIX_W = 8;

    typedef logic [PIX_W-1:0] pix_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

endpackage : adc_readout_pkg

// File: rtl/row_readout_serializer.sv
// Snapshots one row of ADC results on conv_done and streams it out one pixel
// per valid/ready handshake, tagged with pixel index, row index and end-of-row.
module row_readout_serializer
    import adc_readout_pkg::*;
#(
    parameter int NUM_PIXELS = 50,
    parameter int ROW_W      = 10,
    localparam int IDX_W     = $clog2(NUM_PIXELS)
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             conv_done,
    input  logic [NUM_PIXELS-1:0][PIX_W-1:0] adc_values,
    input  logic                             out_ready,
    output logic                             out_valid,
    output pix_t                             out_data,
    output logic [IDX_W-1:0]                 out_pix_idx,
    output logic [ROW_W-1:0]                 out_row_idx,
    output logic                             out_last,
    output logic                             busy,
    output logic                             row_done,
    output logic                             overrun,
    input  logic                             overrun_clr
);

    localparam logic [IDX_W-1:0] PRE_LAST_IDX = IDX_W'(NUM_PIXELS - 2);
    localparam logic [IDX_W-1:0] IDX_ZERO     = {IDX_W{1'b0}};
    localparam logic [ROW_W-1:0] ROW_ONE      = ROW_W'(1);

    state_e                 state_q, state_d;
    pix_t [NUM_PIXELS-1:0]  snap_q;
    logic [IDX_W-1:0]       pix_idx_q, pix_idx_d;
    logic [ROW_W-1:0]       row_idx_q, row_idx_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    logic                   row_done_q, row_done_d;
    logic                   overrun_q, overrun_d;

    logic                   hs_s;
    logic                   last_hs_s;
    logic                   snap_load_s;
    logic                   overrun_set_s;

    assign hs_s      = valid_q & out_ready;
    assign last_hs_s = hs_s & last_q;

    // Next-state logic: row start, pixel advance, row turnover and overrun detection.
    always_comb begin
        state_d       = state_q;
        pix_idx_d     = pix_idx_q;
        row_idx_d     = row_idx_q;
        valid_d       = valid_q;
        last_d        = last_q;
        row_done_d    = 1'b0;
        snap_load_s   = 1'b0;
        overrun_set_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (conv_done) begin
                    snap_load_s = 1'b1;
                    pix_idx_d   = IDX_ZERO;
                    last_d      = 1'b0;
                    valid_d     = 1'b1;
                    state_d     = STREAM;
                end else begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
            end

            STREAM: begin
                if (last_hs_s) begin
                    row_done_d = 1'b1;
                    row_idx_d  = row_idx_q + ROW_ONE;
                    pix_idx_d  = IDX_ZERO;
                    last_d     = 1'b0;
                    // A conv_done on the final handshake chains straight into the next row.
                    if (conv_done) begin
                        snap_load_s = 1'b1;
                        valid_d     = 1'b1;
                        state_d     = STREAM;
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    if (hs_s) begin
                        pix_idx_d = pix_idx_q + IDX_W'(1);
                        last_d    = (pix_idx_q == PRE_LAST_IDX);
                    end else begin
                        pix_idx_d = pix_idx_q;
                        last_d    = last_q;
                    end
                    overrun_set_s = conv_done;
                end
            end

            default: begin
                state_d   = IDLE;
                valid_d   = 1'b0;
                last_d    = 1'b0;
                pix_idx_d = IDX_ZERO;
            end
        endcase
    end

    // Sticky overrun flag; a new overrun wins over a clear in the same cycle.
    always_comb begin
        if (overrun_set_s) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pix_idx_q  <= IDX_ZERO;
            row_idx_q  <= {ROW_W{1'b0}};
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            row_done_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pix_idx_q  <= pix_idx_d;
            row_idx_q  <= row_idx_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            row_done_q <= row_done_d;
            overrun_q  <= overrun_d;
        end
    end

    // Row snapshot; only loaded when a row actually starts, so an overrun cannot corrupt it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_q <= {NUM_PIXELS{{PIX_W{1'b0}}}};
        end else if (snap_load_s) begin
            snap_q <= adc_values;
        end else begin
            snap_q <= snap_q;
        end
    end

    assign out_valid   = valid_q;
    assign busy        = valid_q;
    assign out_data    = snap_q[pix_idx_q];
    assign out_pix_idx = pix_idx_q;
    assign out_row_idx = row_idx_q;
    assign out_last    = last_q;
    assign row_done    = row_done_q;
    assign overrun     = overrun_q;

endmodule : row_readout_serializer

// File: tb/tb_row_readout_serializer.sv
// Scoreboard bench for row_readout_serializer: expected words are queued when a
// row is started and checked against every handshake the DUT performs.
module tb_row_readout_serializer;

    localparam int NP = 50;
    localparam int RW = 2;
    localparam int IW = $clog2(NP);

    typedef struct packed {
        logic [7:0]    data;
        logic [IW-1:0] idx;
        logic [RW-1:0] row;
        logic          last;
    } word_t;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b1;
    logic                     conv_done = 1'b0;
    logic [NP-1:0][7:0]       adc_values = '0;
    logic                     out_ready = 1'b0;
    logic                     out_valid;
    logic [7:0]               out_data;
    logic [IW-1:0]            out_pix_idx;
    logic [RW-1:0]            out_row_idx;
    logic                     out_last;
    logic                     busy;
    logic                     row_done;
    logic                     overrun;
    logic                     overrun_clr = 1'b0;

    int                       errors = 0;
    int                       checks = 0;
    word_t                    sb_q[$];
    logic [RW-1:0]            row_tag = '0;

    logic                     stall_p = 1'b0;
    logic                     hs_last_p = 1'b0;
    logic [$bits(word_t):0]   held_p = '0;

    row_readout_serializer #(
        .NUM_PIXELS (NP),
        .ROW_W      (RW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .conv_done   (conv_done),
        .adc_values  (adc_values),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_pix_idx (out_pix_idx),
        .out_row_idx (out_row_idx),
        .out_last    (out_last),
        .busy        (busy),
        .row_done    (row_done),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_row(input logic [NP-1:0][7:0] vals);
        word_t w;
        for (int i = 0; i < NP; i++) begin
            w.data = vals[i];
            w.idx  = IW'(i);
            w.row  = row_tag;
            w.last = (i == NP - 1);
            sb_q.push_back(w);
        end
        row_tag = row_tag + 2'd1;
    endtask

    // Handshake monitor: order/content scoreboard, stall stability, row_done timing.
    always @(negedge clk) begin
        if (!reset_n) begin
            stall_p   = 1'b0;
            hs_last_p = 1'b0;
        end else begin
            checks++;
            if (row_done !== hs_last_p) begin
                errors++;
                $display("FAIL row_done_timing: got %b expected %b at %0t", row_done, hs_last_p, $time);
            end
            checks++;
            if (busy !== out_valid) begin
                errors++;
                $display("FAIL busy_vs_valid: busy %b valid %b at %0t", busy, out_valid, $time);
            end
            if (stall_p) begin
                checks++;
                if ({out_valid, out_data, out_pix_idx, out_row_idx, out_last} !== held_p) begin
                    errors++;
                    $display("FAIL stall_stable: got %h expected %h at %0t",
                             {out_valid, out_data, out_pix_idx, out_row_idx, out_last}, held_p, $time);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got idx %0d data %h, expected no word", out_pix_idx, out_data);
                end else begin
                    word_t exp_w;
                    word_t got_w;
                    exp_w = sb_q.pop_front();
                    got_w = {out_data, out_pix_idx, out_row_idx, out_last};
                    if (got_w !== exp_w) begin
                        errors++;
                        $display("FAIL word: got data %h idx %0d row %0d last %b, expected data %h idx %0d row %0d last %b",
                                 got_w.data, got_w.idx, got_w.row, got_w.last,
                                 exp_w.data, exp_w.idx, exp_w.row, exp_w.last);
                    end
                end
            end
            stall_p   = (out_valid === 1'b1) && (out_ready !== 1'b1);
            held_p    = {out_valid, out_data, out_pix_idx, out_row_idx, out_last};
            hs_last_p = (out_valid === 1'b1) && (out_ready === 1'b1) && (out_last === 1'b1);
        end
    end

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #2;
        checks++;
        if ({out_valid, out_data, out_pix_idx, out_row_idx, out_last, busy, row_done, overrun} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {out_valid, out_data, out_pix_idx, out_row_idx, out_last, busy, row_done, overrun});
        end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got valid %b busy %b expected 0 0", out_valid, busy);
        end
    endtask

    task automatic test_stream();
        int n;
        for (int i = 0; i < NP; i++) adc_values[i] = 8'(i + 10);
        out_ready = 1'b1;
        conv_done = 1'b1;
        push_row(adc_values);
        tick();
        conv_done = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_pix_idx !== '0 || out_data !== 8'd10) begin
            errors++;
            $display("FAIL first_word: got valid %b idx %0d data %0d expected 1 0 10", out_valid, out_pix_idx, out_data);
        end
        n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (n != NP) begin
            errors++;
            $display("FAIL row_length: got %0d cycles expected %0d", n, NP);
        end
        checks++;
        if (row_done !== 1'b1 || out_row_idx !== 2'd1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL row_end: got row_done %b row %0d valid %b expected 1 1 0", row_done, out_row_idx, out_valid);
        end
        tick();
        checks++;
        if (row_done !== 1'b0) begin
            errors++;
            $display("FAIL row_done_width: got %b expected 0", row_done);
        end
    endtask

    task automatic test_stall();
        int n;
        logic [3:0] pat;
        pat = 4'b1001;
        conv_done = 1'b1;
        push_row(adc_values);
        tick();
        conv_done = 1'b0;
        n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            out_ready = pat[n % 4];
            tick();
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL stall_drain: got %0d words left expected 0", sb_q.size());
        end
        checks++;
        if (row_done !== 1'b1 || out_row_idx !== row_tag) begin
            errors++;
            $display("FAIL stall_row_end: got row_done %b row %0d expected 1 %0d", row_done, out_row_idx, row_tag);
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_overrun();
        int n;
        for (int i = 0; i < NP; i++) adc_values[i] = 8'(i + 100);
        out_ready = 1'b1;
        conv_done = 1'b1;
        push_row(adc_values);
        tick();
        conv_done = 1'b0;
        n = 0;
        while (out_pix_idx !== 6'd20 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL reach_pix20: got idx %0d expected 20", out_pix_idx);
        end
        adc_values = {NP{8'hFF}};
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got %b expected 1", overrun);
        end
        n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (sb_q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL overrun_drain: got %0d left valid %b expected 0 0", sb_q.size(), out_valid);
        end
        tick();
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: got %b expected 0", overrun);
        end
        for (int i = 0; i < NP; i++) adc_values[i] = 8'(i + 60);
        conv_done = 1'b1;
        push_row(adc_values);
        tick();
        conv_done = 1'b0;
        n = 0;
        while (out_pix_idx !== 6'd5 && n < 100) begin
            tick();
            n++;
        end
        adc_values = {NP{8'h3C}};
        conv_done = 1'b1;
        overrun_clr = 1'b1;
        tick();
        conv_done = 1'b0;
        overrun_clr = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_priority: got %b expected 1", overrun);
        end
        n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        tick();
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        checks++;
        if (overrun !== 1'b0 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL overrun_final: got overrun %b left %0d expected 0 0", overrun, sb_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [RW-1:0] new_row;
        for (int i = 0; i < NP; i++) adc_values[i] = 8'(i + 10);
        out_ready = 1'b1;
        conv_done = 1'b1;
        push_row(adc_values);
        tick();
        conv_done = 1'b0;
        n = 0;
        while (out_last !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL reach_last: got last %b expected 1", out_last);
        end
        new_row = row_tag;
        adc_values = {NP{8'hA5}};
        conv_done = 1'b1;
        push_row(adc_values);
        tick();
        conv_done = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_pix_idx !== '0 || out_data !== 8'hA5 ||
            row_done !== 1'b1 || out_row_idx !== new_row || overrun !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back: got valid %b idx %0d data %h row_done %b row %0d ovr %b expected 1 0 a5 1 %0d 0",
                     out_valid, out_pix_idx, out_data, row_done, out_row_idx, overrun, new_row);
        end
        n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: got %0d left expected 0", sb_q.size());
        end
        tick();
    endtask

    task automatic test_reset_midstall();
        int n;
        for (int i = 0; i < NP; i++) adc_values[i] = 8'(i * 3);
        out_ready = 1'b1;
        conv_done = 1'b1;
        push_row(adc_values);
        tick();
        conv_done = 1'b0;
        n = 0;
        while (out_pix_idx !== 6'd30 && n < 100) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_data, out_pix_idx, out_row_idx, out_last, busy, row_done, overrun} !== '0) begin
            errors++;
            $display("FAIL async_reset: got %h expected 0",
                     {out_valid, out_data, out_pix_idx, out_row_idx, out_last, busy, row_done, overrun});
        end
        sb_q.delete();
        row_tag = '0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < NP; i++) adc_values[i] = 8'(i + 1);
        out_ready = 1'b1;
        conv_done = 1'b1;
        push_row(adc_values);
        tick();
        conv_done = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_pix_idx !== '0 || out_row_idx !== '0 || out_data !== 8'd1) begin
            errors++;
            $display("FAIL post_reset_row: got valid %b idx %0d row %0d data %0d expected 1 0 0 1",
                     out_valid, out_pix_idx, out_row_idx, out_data);
        end
        n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL post_reset_drain: got %0d left expected 0", sb_q.size());
        end
        tick();
    endtask

    task automatic test_row_wrap();
        int n;
        #2 reset_n = 1'b0;
        sb_q.delete();
        row_tag = '0;
        tick();
        reset_n = 1'b1;
        tick();
        out_ready = 1'b1;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < NP; i++) adc_values[i] = 8'(r * 16 + i);
            conv_done = 1'b1;
            push_row(adc_values);
            tick();
            conv_done = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_pix_idx !== '0 || out_row_idx !== 2'(r % 4)) begin
                errors++;
                $display("FAIL row_wrap_start: row %0d got valid %b idx %0d row_idx %0d expected 1 0 %0d",
                         r, out_valid, out_pix_idx, out_row_idx, r % 4);
            end
            if (r < 4) begin
                n = 0;
                while (out_last !== 1'b1 && n < 100) begin
                    tick();
                    n++;
                end
            end
        end
        n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (sb_q.size() != 0 || out_row_idx !== 2'd1) begin
            errors++;
            $display("FAIL row_wrap_end: got %0d left row_idx %0d expected 0 1", sb_q.size(), out_row_idx);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_overrun();
        test_back_to_back();
        test_reset_midstall();
        test_row_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_row_readout_serializer

// File: doc/row_readout_serializer.md
# row_readout_serializer

Downstream stage of the per-row single-slope ADC. On a conversion-done strobe, it snapshots all NUM_PIXELS 8-bit conversion results, then streams them out one pixel per handshake over a valid/ready interface, tagged with pixel index, row index and end-of-row. The snapshot frees the ADC to start the next row while the previous row drains.

## Interface
Parameters:
- NUM_PIXELS, 50, pixels per row; must be ≥ 2
- ROW_W, 10, width of the row counter

Ports:
- clk  in  1  single clock
- reset_n  in  1  asynchronous, active-low reset
- conv_done  in  1  one-cycle strobe; ADC row results are final this cycle
- adc_values  in  NUM_PIXELS×8  packed array, element i = pixel i result
- out_ready  in  1  consumer ready
- out_valid  out  1  pixel word valid
- out_data  out  8  pixel result
- out_pix_idx  out  $clog2(NUM_PIXELS)  pixel index, 0..NUM_PIXELS-1
- out_row_idx  out  ROW_W  row number of the current word
- out_last  out  1  high with pixel NUM_PIXELS-1
- busy  out  1  snapshot held, row not fully drained
- row_done  out  1  one-cycle pulse after the last handshake of a row
- overrun  out  1  sticky; conv_done arrived while a row was still busy
- overrun_clr  in  1  synchronous clear of overrun

## Operation
- States: IDLE, STREAM.
- IDLE: out_valid=0, busy=0. When conv_done=1, capture adc_values into the snapshot register, set pix_idx=0, go to STREAM.
- STREAM: out_valid=1, out_data=snapshot[pix_idx], out_last=(pix_idx==NUM_PIXELS-1), busy=1.
  - Handshake = out_valid & out_ready.
  - On a non-last handshake, pix_idx is incremented.
  - On a last handshake, row_done pulses next cycle and out_row_idx is incremented (wraps at 2^ROW_W).
  - After a last handshake with conv_done=0, the block returns to IDLE.
  - After a last handshake with conv_done=1 in the same cycle, the block takes a new snapshot, sets pix_idx=0 and stays in STREAM. No bubble between rows.
- conv_done in STREAM without a last handshake: ignored (snapshot not disturbed) and overrun is set.
- overrun: set has priority over overrun_clr in the same cycle.
- out_data, out_pix_idx, out_row_idx, out_last stay stable while out_valid=1 and out_ready=0.
- Reset (async assert, any state): state=IDLE, out_valid=0, out_data=0, out_pix_idx=0, out_row_idx=0, out_last=0, busy=0, row_done=0, overrun=0, snapshot=0. A row in progress is discarded. Deassertion is used synchronously by the upstream reset synchroniser.

## Timing
- conv_done sampled at edge N: out_valid=1 with pixel 0 from edge N (visible in cycle N+1).
- Throughput: 1 pixel/cycle with out_ready held high. A row takes NUM_PIXELS cycles from the first valid to the last handshake.
- row_done is registered: high for exactly the cycle after the last handshake.
- All outputs are registered, except that out_data is a mux of the registered snapshot by the registered pix_idx (no input-to-output combinational path).
- out_ready has no combinational path to out_valid.

## Structure
- Package adc_readout_pkg holds:
  - PIX_W = 8
  - the state enum (IDLE, STREAM)
  - the typedef for the pixel word
- The ADC row block imports PIX_W from the same package.
- No sub-module. The snapshot register, index counter and output mux are inline; at 50×8 the snapshot is a flat register array.

## Test plan
- Reset, then conv_done with adc_values[i]=i+10, out_ready=1 → 50 consecutive words with data 10..59, idx 0..49, out_last only on idx 49, row_done pulse one cycle after, out_row_idx 0→1.
- Same row, out_ready toggling 1,0,0,1 pattern → every word is held stable while stalled, no drops or duplicates, order preserved.
- conv_done pulsed at pixel 20 of a row → overrun=1, the remaining words come from the original snapshot. Then overrun_clr=1 → overrun=0. Then overrun_clr and a new offending conv_done in the same cycle → overrun stays 1.
- conv_done coincident with the last handshake, new values all 0xA5 → next cycle out_valid=1, idx 0, data 0xA5, no idle cycle, out_row_idx incremented once.
- reset_n asserted at pixel 30, mid-stall → all outputs go to 0 immediately (asynchronously). After release, a new conv_done streams from idx 0 with out_row_idx=0.
- 2^ROW_W+1 rows with ROW_W=2 → out_row_idx sequence 0,1,2,3,0.
